// File: rtl/svc_sram_io_ctrl.sv
// svc_sram_io_ctrl: back-end driver for an external asynchronous SRAM.
// Takes one command at a time from the sram_cmd_* handshake, generates
// CE#/OE#/WE#/BE# timing with programmable write-pulse and read-access
// widths, and returns read data with its meta through a one-entry slot.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | reset state, leaves on the first edge after reset release
// IDLE     | pins parked, cmd_ready high, bus turnaround cycle
// WR       | WE# low, data driven, counting the write pulse
// WR_HOLD  | WE# high, CE# low, data/addr still driven for hold time
// RD       | OE# low, counting access time, samples when the slot frees
module svc_sram_io_ctrl #(
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int SRAM_META_WIDTH = 5,
  parameter int WR_CYCLES       = 2,
  parameter int RD_CYCLES       = 2,
  localparam int STRBW          = SRAM_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sram_cmd_valid,
  output logic                       sram_cmd_ready,
  input  logic                       sram_cmd_wr_en,
  input  logic [SRAM_ADDR_WIDTH-1:0] sram_cmd_addr,
  input  logic [SRAM_META_WIDTH-1:0] sram_cmd_meta,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_cmd_wr_data,
  input  logic [STRBW-1:0]           sram_cmd_wr_strb,
  output logic                       sram_rd_resp_valid,
  input  logic                       sram_rd_resp_ready,
  output logic [SRAM_DATA_WIDTH-1:0] sram_rd_resp_data,
  output logic [SRAM_META_WIDTH-1:0] sram_rd_resp_meta,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_io_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_io_data_o,
  output logic                       sram_io_data_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_io_data_i,
  output logic                       sram_io_ce_n,
  output logic                       sram_io_oe_n,
  output logic                       sram_io_we_n,
  output logic [STRBW-1:0]           sram_io_be_n
);

  localparam int CMAX  = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_WR      = 3'd2,
    S_WR_HOLD = 3'd3,
    S_RD      = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SRAM_DATA_WIDTH-1:0] data_q, data_d;
  logic [STRBW-1:0]           strb_q, strb_d;
  logic [SRAM_META_WIDTH-1:0] meta_q, meta_d;

  logic                       resp_valid_q, resp_valid_d;
  logic [SRAM_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [SRAM_META_WIDTH-1:0] resp_meta_q, resp_meta_d;

  logic                       cmd_ready_q, cmd_ready_d;
  logic [SRAM_ADDR_WIDTH-1:0] io_addr_q, io_addr_d;
  logic [SRAM_DATA_WIDTH-1:0] io_data_o_q, io_data_o_d;
  logic                       io_data_oe_q, io_data_oe_d;
  logic                       ce_n_q, ce_n_d;
  logic                       oe_n_q, oe_n_d;
  logic                       we_n_q, we_n_d;
  logic [STRBW-1:0]           be_n_q, be_n_d;

  logic                       load;

  // Next state, command latch, response slot and next pin values.
  // Pins are derived from the next state so they are registered yet
  // change on the same edge as the state they belong to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strb_d       = strb_q;
    meta_d       = meta_q;
    load         = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_meta_d  = resp_meta_q;

    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (sram_cmd_valid && cmd_ready_q) begin
          addr_d = sram_cmd_addr;
          data_d = sram_cmd_wr_data;
          strb_d = sram_cmd_wr_strb;
          meta_d = sram_cmd_meta;
          if (sram_cmd_wr_en) begin
            state_d = S_WR;
            cnt_d   = CNT_W'(WR_CYCLES - 1);
          end else begin
            state_d = S_RD;
            cnt_d   = CNT_W'(RD_CYCLES - 1);
          end
        end
      end
      S_WR: begin
        if (cnt_q == '0) state_d = S_WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_WR_HOLD: state_d = S_IDLE;
      S_RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!resp_valid_q || sram_rd_resp_ready) begin
          // Sample only when the slot can take it; otherwise hold pins.
          load    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    // A new sample takes priority over the consumer's pop.
    if (load) begin
      resp_valid_d = 1'b1;
      resp_data_d  = sram_io_data_i;
      resp_meta_d  = meta_q;
    end else if (resp_valid_q && sram_rd_resp_ready) begin
      resp_valid_d = 1'b0;
    end

    cmd_ready_d  = 1'b0;
    io_addr_d    = io_addr_q;
    io_data_o_d  = io_data_o_q;
    io_data_oe_d = 1'b0;
    ce_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    be_n_d       = {STRBW{1'b1}};

    case (state_d)
      S_IDLE: cmd_ready_d = 1'b1;
      S_WR: begin
        ce_n_d       = 1'b0;
        we_n_d       = 1'b0;
        be_n_d       = ~strb_d;
        io_data_oe_d = 1'b1;
        io_addr_d    = addr_d;
        io_data_o_d  = data_d;
      end
      S_WR_HOLD: begin
        ce_n_d       = 1'b0;
        be_n_d       = ~strb_d;
        io_data_oe_d = 1'b1;
        io_addr_d    = addr_d;
        io_data_o_d  = data_d;
      end
      S_RD: begin
        ce_n_d    = 1'b0;
        oe_n_d    = 1'b0;
        be_n_d    = '0;
        io_addr_d = addr_d;
      end
      default: ;
    endcase
  end

  // State, latches, response slot and pin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      meta_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_meta_q  <= '0;
      cmd_ready_q  <= 1'b0;
      io_addr_q    <= '0;
      io_data_o_q  <= '0;
      io_data_oe_q <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= {STRBW{1'b1}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      meta_q       <= meta_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_meta_q  <= resp_meta_d;
      cmd_ready_q  <= cmd_ready_d;
      io_addr_q    <= io_addr_d;
      io_data_o_q  <= io_data_o_d;
      io_data_oe_q <= io_data_oe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
    end
  end

  assign sram_cmd_ready     = cmd_ready_q;
  assign sram_rd_resp_valid = resp_valid_q;
  assign sram_rd_resp_data  = resp_data_q;
  assign sram_rd_resp_meta  = resp_meta_q;
  assign sram_io_addr       = io_addr_q;
  assign sram_io_data_o     = io_data_o_q;
  assign sram_io_data_oe    = io_data_oe_q;
  assign sram_io_ce_n       = ce_n_q;
  assign sram_io_oe_n       = oe_n_q;
  assign sram_io_we_n       = we_n_q;
  assign sram_io_be_n       = be_n_q;

endmodule
